// File: rtl/counter_timer_arbiter.sv
// ---------------------------------------------------------------------------
// counter_timer_arbiter
//
// Shares one up-counting interval timer between two requesters. In IDLE the
// block picks a winner among the raised requests, latches that requester's
// terminal count and grants it. In RUN the counter advances on each tick until
// it reaches the terminal count. The following cycle is DONE, where a one-cycle
// done pulse goes to the owner. The block then returns to IDLE. The owner can
// cancel an interval in RUN with abort, which gives no done pulse.
//
// Optional feature (compile-time macro):
//   CTA_FAIR_RR_EN  defined   : a tie goes to the round-robin pointer rr, which
//                               is set to ~owner whenever an interval ends.
//   CTA_FAIR_RR_EN  undefined : fixed priority; requester 0 wins a tie.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous reset, active low
//   req    in   2      request levels, sampled only in IDLE
//   len0   in   CNT_W  requester 0 terminal count (interval = len0+1 ticks)
//   len1   in   CNT_W  requester 1 terminal count (interval = len1+1 ticks)
//   tick   in   1      count enable, honoured only in RUN
//   abort  in   1      cancel the current interval, honoured only in RUN
//   gnt    out  2      one-hot grant (registered)
//   cnt    out  CNT_W  current count (registered)
//   done   out  2      one-cycle completion pulse to the owner (registered)
//   busy   out  1      high in RUN and DONE
// ---------------------------------------------------------------------------
module counter_timer_arbiter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  input  logic             tick,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q,   gnt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] tc_q,    tc_d;
  logic [1:0]       done_q,  done_d;
  logic             owner_q, owner_d;   // index of the granted requester
  logic             winner;             // arbitration result in IDLE

`ifdef CTA_FAIR_RR_EN
  logic             rr_q,    rr_d;      // requester favoured on a tie

  always_comb begin
    if (req[0] && req[1]) winner = rr_q;
    else                  winner = req[1];
  end
`else
  // Requester 0 wins whenever it asks, so the tie case needs no pointer.
  always_comb winner = ~req[0];
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    owner_d = owner_q;
    done_d  = 2'b00;                    // done is a pulse unless set below
`ifdef CTA_FAIR_RR_EN
    rr_d    = rr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = winner;
          tc_d    = winner ? len1 : len0;
          cnt_d   = '0;
          gnt_d   = winner ? 2'b10 : 2'b01;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          // Abort takes precedence over a simultaneous tick; no done pulse.
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          cnt_d   = '0;
`ifdef CTA_FAIR_RR_EN
          rr_d    = ~owner_q;
`endif
        end else if (tick) begin
          if (cnt_q == tc_q) begin
            // Terminal tick: the count holds at tc rather than wrapping.
            state_d = S_DONE;
            done_d  = owner_q ? 2'b10 : 2'b01;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
`ifdef CTA_FAIR_RR_EN
        rr_d    = ~owner_q;
`endif
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      tc_q    <= '0;
      done_q  <= 2'b00;
      owner_q <= 1'b0;
`ifdef CTA_FAIR_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      owner_q <= owner_d;
`ifdef CTA_FAIR_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign cnt  = cnt_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for counter_timer_arbiter (CNT_W = 3).
// A reference model tracks the interval as an owner, a captured length and a
// number of ticks received. The expected count is derived from those values.
// It also covers CTA_FAIR_RR_EN when the macro is defined for the bench.
// ---------------------------------------------------------------------------
module tb_counter_timer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [2:0] len0, len1;
  logic       tick, abort;
  logic [1:0] gnt;
  logic [2:0] cnt;
  logic [1:0] done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  counter_timer_arbiter #(.CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .tick (tick),
    .abort(abort),
    .gnt  (gnt),
    .cnt  (cnt),
    .done (done),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (interval level) ----------------
  bit m_active;     // an interval is granted and still counting
  bit m_finished;   // the interval has collected all its ticks (done cycle)
  int m_owner;
  int m_len;        // interval length in ticks (captured len + 1)
  int m_ticks;      // ticks received so far
  int m_rr;

  task automatic m_reset();
    m_active = 0; m_finished = 0; m_owner = 0; m_len = 0; m_ticks = 0; m_rr = 0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic m_update();
    int w;
    if (!rst) begin
      m_reset();
    end else if (m_finished) begin
      m_finished = 0;
      m_rr = 1 - m_owner;
    end else if (m_active) begin
      if (abort) begin
        m_active = 0;
        m_rr = 1 - m_owner;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == m_len) begin
          m_active = 0;
          m_finished = 1;
        end
      end
    end else if (req != 2'b00) begin
      if (req == 2'b11) begin
`ifdef CTA_FAIR_RR_EN
        w = m_rr;
`else
        w = 0;
`endif
      end else begin
        w = req[1] ? 1 : 0;
      end
      m_owner  = w;
      m_len    = ((w == 1) ? int'(len1) : int'(len0)) + 1;
      m_ticks  = 0;
      m_active = 1;
    end
  endtask

  task automatic m_compare();
    logic [1:0] eg, ed;
    logic [2:0] ec;
    logic       eb;
    eg = (m_active || m_finished) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    ed = m_finished ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    ec = m_finished ? 3'(m_len - 1) : (m_active ? 3'(m_ticks) : 3'd0);
    eb = m_active || m_finished;
    check("mdl_gnt",  32'(gnt),  32'(eg));
    check("mdl_cnt",  32'(cnt),  32'(ec));
    check("mdl_done", 32'(done), 32'(ed));
    check("mdl_busy", 32'(busy), 32'(eb));
  endtask

  // One clock: model steps on the pre-edge inputs, DUT sampled 1 ns after.
  task automatic step();
    m_update();
    @(posedge clk);
    #1;
    m_compare();
  endtask

  task automatic drive(input logic r, input logic [1:0] q, input logic [2:0] l0,
                       input logic [2:0] l1, input logic t, input logic a);
    rst = r; req = q; len0 = l0; len1 = l1; tick = t; abort = a;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [2:0] len0, len1;
    logic       tick, abort;
    logic [1:0] gnt;
    logic [2:0] cnt;
    logic [1:0] done;
    logic       busy;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [1:0] q, input logic [2:0] l0, input logic [2:0] l1,
                              input logic t, input logic a, input logic [1:0] g,
                              input logic [2:0] c, input logic [1:0] d, input logic b);
    vec_t v;
    v.rst = 1'b1; v.req = q; v.len0 = l0; v.len1 = l1; v.tick = t; v.abort = a;
    v.gnt = g; v.cnt = c; v.done = d; v.busy = b;
    return v;
  endfunction

  task automatic tie_test(input logic [1:0] e0, input logic [1:0] e1);
    logic [1:0] prev;
    logic [1:0] grants[$];
    drive(1'b1, 2'b11, 3'd1, 3'd1, 1'b1, 1'b0);
    prev = gnt;
    for (int i = 0; i < 16; i++) begin
      step();
      if (prev == 2'b00 && gnt != 2'b00) grants.push_back(gnt);
      prev = gnt;
    end
    req = 2'b00;
    check("tie_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++)
      check($sformatf("tie_grant_%0d", i), 32'(grants[i]), 32'((i % 2 == 0) ? e0 : e1));
  endtask

  initial begin
    logic [1:0] hold;
    m_reset();
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    do_reset();

    // Single requester len0=3, len1=0 boundary, then an abort.
    vecs[0]  = mk(2'b01, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 3'd0, 2'b00, 1'b1);
    vecs[1]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 3'd1, 2'b00, 1'b1);
    vecs[2]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 3'd2, 2'b00, 1'b1);
    vecs[3]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 3'd3, 2'b00, 1'b1);
    vecs[4]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 3'd3, 2'b01, 1'b1);
    vecs[5]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0);
    vecs[6]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0);
    vecs[7]  = mk(2'b10, 3'd3, 3'd0, 1'b0, 1'b0, 2'b10, 3'd0, 2'b00, 1'b1);
    vecs[8]  = mk(2'b00, 3'd3, 3'd0, 1'b0, 1'b0, 2'b10, 3'd0, 2'b00, 1'b1);
    vecs[9]  = mk(2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 2'b10, 3'd0, 2'b10, 1'b1);
    vecs[10] = mk(2'b00, 3'd3, 3'd0, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0);
    vecs[11] = mk(2'b01, 3'd5, 3'd0, 1'b0, 1'b0, 2'b01, 3'd0, 2'b00, 1'b1);
    vecs[12] = mk(2'b00, 3'd5, 3'd0, 1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 1'b0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].len0, vecs[i].len1, vecs[i].tick, vecs[i].abort);
      step();
      check($sformatf("tbl%0d_gnt", i),  32'(gnt),  32'(vecs[i].gnt));
      check($sformatf("tbl%0d_cnt", i),  32'(cnt),  32'(vecs[i].cnt));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Asynchronous reset mid-RUN with cnt=2, then tie arbitration from rr=0.
    drive(1'b1, 2'b01, 3'd5, 3'd0, 1'b1, 1'b0);
    step();
    req = 2'b00;
    step();
    step();
    check("rst_pre_cnt", 32'(cnt), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check("rst_async_gnt",  32'(gnt),  32'd0);
    check("rst_async_cnt",  32'(cnt),  32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
`ifdef CTA_FAIR_RR_EN
    tie_test(2'b01, 2'b10);
`else
    tie_test(2'b01, 2'b01);
`endif

    // len1=7 with tick on alternate cycles (0,1,0,1,...).
    do_reset();
    drive(1'b1, 2'b10, 3'd0, 3'd7, 1'b0, 1'b0);
    step();
    req = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      tick = (k % 2 == 0);
      step();
      if (k == 14) check("gate_cnt7_at14", 32'(cnt), 32'd7);
      if (k == 15) begin
        check("gate_hold7", 32'(cnt), 32'd7);
        check("gate_no_done", 32'(done), 32'd0);
      end
    end
    check("gate_done", 32'(done), 32'b10);
    check("gate_done_cnt", 32'(cnt), 32'd7);
    tick = 1'b0;
    step();
    check("gate_idle_gnt", 32'(gnt), 32'd0);

    // Abort with cnt=2 and a simultaneous tick; rr flips to requester 1.
    do_reset();
    drive(1'b1, 2'b01, 3'd5, 3'd5, 1'b1, 1'b0);
    step();
    req = 2'b00;
    step();
    step();
    check("abort_pre_cnt", 32'(cnt), 32'd2);
    abort = 1'b1;
    step();
    check("abort_gnt",  32'(gnt),  32'd0);
    check("abort_cnt",  32'(cnt),  32'd0);
    check("abort_done", 32'(done), 32'd0);
    abort = 1'b0;
    req = 2'b11;
    step();
`ifdef CTA_FAIR_RR_EN
    check("abort_rr_flip", 32'(gnt), 32'b10);
`else
    check("abort_fixed_prio", 32'(gnt), 32'b01);
`endif
    req = 2'b00;
    for (int i = 0; i < 8; i++) step();

    // Mid-run len0 change and req drop: the interval keeps the captured len.
    drive(1'b1, 2'b01, 3'd2, 3'd0, 1'b1, 1'b0);
    step();
    req = 2'b00;
    len0 = 3'd6;
    step();
    step();
    step();
    check("midrun_done", 32'(done), 32'b01);
    check("midrun_cnt",  32'(cnt),  32'd2);
    step();

    // Randomised traffic against the model.
    hold = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (gnt[r]) hold[r] = 1'b0;
        else if ($urandom_range(99) < 30) hold[r] = 1'b1;
      end
      req   = hold;
      len0  = 3'($urandom_range(7));
      len1  = 3'($urandom_range(7));
      tick  = ($urandom_range(99) < 70);
      abort = ($urandom_range(99) < 5);
      rst   = !($urandom_range(999) < 5);
      if (!rst) hold = 2'b00;
      step();
      if (done != 2'b00) check("rnd_done_matches_gnt", 32'(done), 32'(gnt));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter_timer_arbiter.md
# counter_timer_arbiter

- Shares one 3-bit up-count timer between two requesters; each requester asks for an interval of 1..8 ticks.
- Arbitrates between the requesters, holds the grant for the whole interval, sequences the count and signals completion with a one-cycle done pulse.
- Sits between the requesting control blocks and the tick source; `cnt` is exported for observation.

## Interface
- `CNT_W`, default 3: counter and length width. The block is verified only at 3.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-low.
- `req`  in  2  — per-requester request level.
  - Sampled only in IDLE.
  - The requester holds it until it sees its grant.
- `len0`  in  CNT_W  — requester 0 terminal count; interval is `len0`+1 ticks.
- `len1`  in  CNT_W  — requester 1 terminal count; interval is `len1`+1 ticks.
- `tick`  in  1  — count-enable strobe; counts only in RUN.
- `abort`  in  1  — cancels the interval in progress; honoured in RUN only.
- `gnt`  out  2  — one-hot grant, registered.
- `cnt`  out  CNT_W  — current count, registered.
- `done`  out  2  — one-cycle completion pulse to the owner, registered.
- `busy`  out  1  — high in RUN and DONE.

## Operation
- Reset value of every output is 0: `gnt`=00, `cnt`=0, `done`=00, `busy`=0. State=IDLE, priority pointer `rr`=0.
- States: IDLE, RUN, DONE.
- **IDLE**
  - If any `req` is high, select a winner.
  - Latch the winner's `len` into the terminal register `tc`, set `cnt`=0, assert `gnt[winner]`, then go to RUN.
- **Winner selection**
  - Only one requester high: that requester wins.
  - Both high: requester `rr` wins.
- **RUN**
  - `abort`=1: go to IDLE. `gnt` is cleared, `cnt` is cleared and no done pulse is issued. `abort` wins over a simultaneous `tick`.
  - Otherwise, `tick`=1 with `cnt`==`tc`: go to DONE, `cnt` holds.
  - Otherwise, `tick`=1: `cnt` increments by 1.
  - `tick`=0: hold.
  - `req` changes during RUN are ignored; the owner must use `abort` to release early.
- **DONE**
  - `done[owner]`=1 for exactly this cycle; `gnt` is still asserted and `cnt`=`tc`.
  - Next edge: go to IDLE, `gnt`=00, `cnt`=0.
- Pointer update: when an interval ends (DONE exit or abort), `rr` is set to ~owner.
- Arithmetic: `cnt` never wraps. With `len`=7 it stops at 7 and terminates, and never passes through 0 in RUN.
- `len` values are captured only at grant; changes during RUN have no effect.
- Reset mid-operation: all state returns to reset values immediately. No done pulse.

## Timing
- Grant latency: `req` high at an IDLE edge gives `gnt` high after that edge, i.e. 1 cycle.
- Interval with a continuous `tick`: RUN lasts `len`+1 cycles, followed by 1 DONE cycle.
  - Example: grant at edge 0, RUN cycles 1..4 for `len`=3, `done` high in cycle 5.
- Back-to-back: at least one IDLE cycle between intervals. The earliest next grant is 2 edges after the `done` cycle begins.
- `done` and `gnt` are never asserted for different requesters in the same cycle.
- Abort latency: `abort` sampled high in RUN gives `gnt`=00 after the next edge.

## Configuration
- `CTA_FAIR_RR_EN` defined: round-robin selection as above, using `rr`.
- `CTA_FAIR_RR_EN` undefined: fixed priority. `req[0]` always wins a tie, `rr` is not implemented and everything else is unchanged.

## Test plan
- Reset: `rst` low mid-RUN with `cnt`=2 → all outputs 0 asynchronously. After release, IDLE with `rr`=0.
- Single requester: `req`=01, `len0`=3, `tick` held 1 → `gnt`=01 one cycle later. `cnt` goes 0,1,2,3, then `done`=01 for one cycle, then `gnt`=00.
- Tie and fairness (`CTA_FAIR_RR_EN`): `req`=11 held, `len0`=`len1`=1 → grants alternate 01,10,01,10 with one IDLE gap each. Without the macro → 01 every time.
- Tick gating and wrap: `len1`=7 with `tick` on alternate cycles → `cnt` reaches 7 after 14 RUN cycles, `done`=10 after the 8th tick, and `cnt` never shows 0 after 7.
- Abort: abort in RUN with `cnt`=2 and `tick`=1 in the same cycle → next edge `gnt`=00 and `cnt`=0, no `done`; `rr` flips.
- Mid-run changes: changing `len0` and dropping `req[0]` during RUN → interval completes with the original `len`.
